spi_master: RTL and testbench

- SPI master for the I/O slot at 0xFFFFD0/0xFFFFD4, where the address decoder asserts stb for bus_addr[5:3] == 3'b010.
- Drives the SD card (ss 0) and a network/aux device (ss 1).
- Inputs come straight from the shared CPU bus; data_out and ack feed the top-level read and ack multiplexers.
- Mode 0 (CPOL=0, CPHA=0), MSB first, byte transfers with selectable slow/fast SCLK.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_master_if.sv | 21 ++
 rtl/spi_shifter.sv | 137 +++++++++++++
 rtl/spi_master.sv | 129 ++++++++++++
 tb/tb_spi_master.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master slot.
// Build option SPI_WIDE_EN widens the shift path to 32 bits.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_e;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_CTRL = 1'b1;

  localparam int CTRL_SS_LSB = 0;
  localparam int CTRL_SS_MSB = 1;
  localparam int CTRL_FAST   = 2;
  localparam int CTRL_WIDE   = 3;

  localparam int DIV_W = 7;
  localparam int CNT_W = 5;

`ifdef SPI_WIDE_EN
  localparam int XFER_W = 32;
`else
  localparam int XFER_W = 8;
`endif

endpackage

// File: rtl/spi_master_if.sv
// CPU-side register bus for the SPI master slot.
interface spi_master_if;

  logic        stb;
  logic        we;
  logic        addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (
    output stb, we, addr, data_in,
    input  data_out, ack
  );

  modport slave (
    input  stb, we, addr, data_in,
    output data_out, ack
  );

endinterface

// File: rtl/spi_shifter.sv
// SPI mode-0 engine: half-period divider, IDLE/LOW/HIGH FSM, shift register and bit counter.
// With SPI_WIDE_EN the wide input selects 32-bit transfers.
module spi_shifter
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIV_W-1:0]  div,
  input  logic              wide,
  input  logic [XFER_W-1:0] data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              done,
  output logic [XFER_W-1:0] rx
);

  spi_state_e        state_r;
  logic [DIV_W-1:0]  div_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [XFER_W-1:0] shreg_r;
  logic [XFER_W-1:0] rx_r;
  logic              sample_r;
  logic              sclk_r;
  logic              mosi_r;

  logic [XFER_W-1:0] shifted_s;
  logic [XFER_W-1:0] rx_next_s;
  logic              load_msb_s;
  logic              shift_msb_s;
  logic [CNT_W-1:0]  load_cnt_s;

  assign shifted_s = {shreg_r[XFER_W-2:0], sample_r};

`ifdef SPI_WIDE_EN
  logic wide_r;

  assign load_msb_s  = wide ? data[31] : data[7];
  assign shift_msb_s = wide_r ? shifted_s[31] : shifted_s[7];
  assign load_cnt_s  = wide ? 5'd31 : 5'd7;
  assign rx_next_s   = wide_r ? shifted_s : {24'd0, shifted_s[7:0]};

  // Transfer width is frozen at start so a mid-transfer control write cannot change it
  always_ff @(posedge clk) begin
    if (rst) begin
      wide_r <= 1'b0;
    end else if (state_r == ST_IDLE && start) begin
      wide_r <= wide;
    end else begin
      wide_r <= wide_r;
    end
  end
`else
  logic unused_wide_s;

  assign unused_wide_s = wide;
  assign load_msb_s    = data[7];
  assign shift_msb_s   = shifted_s[7];
  assign load_cnt_s    = 5'd7;
  assign rx_next_s     = shifted_s;
`endif

  // Ends the last HIGH half-period; the top uses it to raise rdy on this same edge
  assign done = (state_r == ST_HIGH) && (div_cnt_r == {DIV_W{1'b0}}) &&
                (bit_cnt_r == {CNT_W{1'b0}});

  // Serial engine FSM with registered sclk/mosi
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      div_r     <= {DIV_W{1'b0}};
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      shreg_r   <= {XFER_W{1'b0}};
      rx_r      <= {XFER_W{1'b0}};
      sample_r  <= 1'b0;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          sclk_r <= 1'b0;
          if (start) begin
            state_r   <= ST_LOW;
            div_r     <= div;
            div_cnt_r <= div - 7'd1;
            bit_cnt_r <= load_cnt_s;
            shreg_r   <= data;
            mosi_r    <= load_msb_s;
          end else begin
            mosi_r <= 1'b1;
          end
        end
        ST_LOW: begin
          if (div_cnt_r == {DIV_W{1'b0}}) begin
            state_r   <= ST_HIGH;
            sclk_r    <= 1'b1;
            sample_r  <= miso;
            div_cnt_r <= div_r - 7'd1;
          end else begin
            div_cnt_r <= div_cnt_r - 7'd1;
          end
        end
        ST_HIGH: begin
          if (div_cnt_r == {DIV_W{1'b0}}) begin
            sclk_r  <= 1'b0;
            shreg_r <= shifted_s;
            if (bit_cnt_r == {CNT_W{1'b0}}) begin
              state_r <= ST_IDLE;
              mosi_r  <= 1'b1;
              rx_r    <= rx_next_s;
            end else begin
              state_r   <= ST_LOW;
              mosi_r    <= shift_msb_s;
              bit_cnt_r <= bit_cnt_r - 5'd1;
              div_cnt_r <= div_r - 7'd1;
            end
          end else begin
            div_cnt_r <= div_cnt_r - 7'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          sclk_r  <= 1'b0;
          mosi_r  <= 1'b1;
        end
      endcase
    end
  end

  assign sclk = sclk_r;
  assign mosi = mosi_r;
  assign rx   = rx_r;

endmodule

// File: rtl/spi_master.sv
// SPI master I/O slot: data/control registers, miso synchroniser and read mux around spi_shifter.
// Build option SPI_WIDE_EN adds the control wide bit and 32-bit transfers.
module spi_master
  import spi_pkg::*;
#(
  parameter int SLOW_DIV = 63,
  parameter int FAST_DIV = 2
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.slave  bus,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic [1:0]   spi_ss_n
);

  localparam logic [DIV_W-1:0] SLOW_DIV_C = DIV_W'(SLOW_DIV);
  localparam logic [DIV_W-1:0] FAST_DIV_C = DIV_W'(FAST_DIV);

  logic [1:0]        ss_n_r;
  logic              fast_r;
  logic              wide_s;
  logic              rdy_r;
  logic              miso_meta_r;
  logic              miso_sync_r;

  logic              wr_ctrl_s;
  logic              wr_data_s;
  logic              start_s;
  logic              done_s;
  logic [DIV_W-1:0]  div_s;
  logic [XFER_W-1:0] rx_s;

  assign wr_ctrl_s = bus.stb && bus.we && (bus.addr == REG_CTRL);
  assign wr_data_s = bus.stb && bus.we && (bus.addr == REG_DATA);
  // Data writes while busy are dropped, not queued
  assign start_s   = wr_data_s && rdy_r;
  assign div_s     = fast_r ? FAST_DIV_C : SLOW_DIV_C;

  // Control register and ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_n_r <= 2'b11;
      fast_r <= 1'b0;
      rdy_r  <= 1'b1;
    end else begin
      if (wr_ctrl_s) begin
        ss_n_r <= ~bus.data_in[CTRL_SS_MSB:CTRL_SS_LSB];
        fast_r <= bus.data_in[CTRL_FAST];
      end else begin
        ss_n_r <= ss_n_r;
        fast_r <= fast_r;
      end
      if (done_s) begin
        rdy_r <= 1'b1;
      end else if (start_s) begin
        rdy_r <= 1'b0;
      end else begin
        rdy_r <= rdy_r;
      end
    end
  end

`ifdef SPI_WIDE_EN
  logic wide_r;

  // Wide-transfer control bit
  always_ff @(posedge clk) begin
    if (rst) begin
      wide_r <= 1'b0;
    end else if (wr_ctrl_s) begin
      wide_r <= bus.data_in[CTRL_WIDE];
    end else begin
      wide_r <= wide_r;
    end
  end

  assign wide_s = wide_r;
`else
  logic unused_data_s;

  assign unused_data_s = ^bus.data_in[31:8];
  assign wide_s        = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous miso pin
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_meta_r <= 1'b0;
      miso_sync_r <= 1'b0;
    end else begin
      miso_meta_r <= spi_miso;
      miso_sync_r <= miso_meta_r;
    end
  end

  spi_shifter u_shifter (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .div   (div_s),
    .wide  (wide_s),
    .data  (bus.data_in[XFER_W-1:0]),
    .miso  (miso_sync_r),
    .sclk  (spi_sclk),
    .mosi  (spi_mosi),
    .done  (done_s),
    .rx    (rx_s)
  );

  // Zero-wait-state, side-effect-free read mux
  always_comb begin
    bus.data_out = 32'd0;
    case (bus.addr)
      REG_CTRL: bus.data_out = {31'd0, rdy_r};
`ifdef SPI_WIDE_EN
      REG_DATA: bus.data_out = rx_s;
`else
      REG_DATA: bus.data_out = {24'd0, rx_s};
`endif
      default:  bus.data_out = 32'd0;
    endcase
  end

  assign bus.ack  = bus.stb;
  assign spi_ss_n = ss_n_r;

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master with a shift-out slave model on miso.
// Build with SPI_WIDE_EN defined to exercise the 32-bit transfer path.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic [1:0] spi_ss_n;

  spi_master_if bus ();

  spi_master dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n)
  );

  always #10 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] slave_sr = 32'd0;
  logic [31:0] mosi_log = 32'd0;
  int          rise_cnt = 0;
  int          rise_cyc [2];
  logic        ss_mon_en = 1'b0;
  logic [1:0]  ss_exp = 2'b11;
  int          ss_bad = 0;

  always @(posedge clk) cyc++;

  // Slave shifts out MSB first, advancing after each rising SCLK edge
  assign spi_miso = slave_sr[31];

  always @(posedge spi_sclk) begin
    mosi_log = {mosi_log[30:0], spi_mosi};
    if (rise_cnt < 2) rise_cyc[rise_cnt] = cyc;
    rise_cnt++;
    slave_sr = slave_sr << 1;
  end

  always @(negedge clk) begin
    if (ss_mon_en && spi_ss_n !== ss_exp) ss_bad++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge captures the write
  task automatic bus_write(input logic a, input logic [31:0] d);
    bus.stb     = 1'b1;
    bus.we      = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    @(negedge clk);
    bus.stb = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] d);
    bus.stb  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    d = bus.data_out;
    bus.stb = 1'b0;
  endtask

  // Counts negedges with rdy low, starting at the current negedge
  task automatic wait_rdy(output int n);
    logic [31:0] d;
    n = 0;
    bus_read(1'b1, d);
    while (d[0] == 1'b0 && n < 5000) begin
      n++;
      @(negedge clk);
      bus_read(1'b1, d);
    end
  endtask

  task automatic start_xfer(input logic [31:0] d, input logic [31:0] slv);
    slave_sr = slv;
    mosi_log = 32'd0;
    rise_cnt = 0;
    bus_write(1'b0, d);
  endtask

  initial begin
    logic [31:0] rd;
    int          n;
    int          k;

    rst         = 1'b1;
    bus.stb     = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = 1'b0;
    bus.data_in = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_val("rst_ss_n", {30'd0, spi_ss_n}, 32'd3);
    check_val("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    check_val("rst_mosi", {31'd0, spi_mosi}, 32'd1);
    bus_read(1'b1, rd);
    check_val("rst_ctrl", rd, 32'h0000_0001);
    bus_read(1'b0, rd);
    check_val("rst_data", rd, 32'h0000_0000);
    bus.stb = 1'b1;
    #1;
    check_val("ack_hi", {31'd0, bus.ack}, 32'd1);
    bus.stb = 1'b0;
    #1;
    check_val("ack_lo", {31'd0, bus.ack}, 32'd0);
    @(negedge clk);

    // Fast byte 0xA5, slave returns 0x3C
    bus_write(1'b1, 32'h5);
    check_val("ss0_sel", {30'd0, spi_ss_n}, 32'd2);
    ss_exp    = 2'b10;
    ss_mon_en = 1'b1;
    start_xfer(32'hA5, 32'h3C00_0000);
    wait_rdy(n);
    check_val("fast_busy", n, 32'd32);
    check_val("fast_mosi", mosi_log, 32'h0000_00A5);
    check_val("fast_rises", rise_cnt, 32'd8);
    bus_read(1'b0, rd);
    check_val("fast_rx", rd, 32'h0000_003C);

    // Slow byte 0xFF, slave returns 0x81
    bus_write(1'b1, 32'h1);
    start_xfer(32'hFF, 32'h8100_0000);
    wait_rdy(n);
    check_val("slow_busy", n, 32'd1008);
    check_val("slow_period", rise_cyc[1] - rise_cyc[0], 32'd126);
    check_val("slow_mosi", mosi_log, 32'h0000_00FF);
    bus_read(1'b0, rd);
    check_val("slow_rx", rd, 32'h0000_0081);
    check_val("slow_ss_hold", ss_bad, 32'd0);
    ss_mon_en = 1'b0;

    // Data write while busy is dropped
    bus_write(1'b1, 32'h5);
    start_xfer(32'h22, 32'h5A00_0000);
    bus_write(1'b0, 32'h11);
    wait_rdy(n);
    check_val("busy_wr_time", n, 32'd31);
    check_val("busy_wr_mosi", mosi_log, 32'h0000_0022);
    bus_read(1'b0, rd);
    check_val("busy_wr_rx", rd, 32'h0000_005A);

    // Control write mid-transfer: ss_n moves at once, speed stays latched
    start_xfer(32'h96, 32'h6900_0000);
    bus_read(1'b0, rd);
    check_val("busy_old_rx", rd, 32'h0000_005A);
    bus_write(1'b1, 32'h2);
    check_val("mid_ss_n", {30'd0, spi_ss_n}, 32'd1);
    wait_rdy(n);
    check_val("mid_ctrl_time", n, 32'd31);
    check_val("mid_ctrl_mosi", mosi_log, 32'h0000_0096);
    bus_read(1'b0, rd);
    check_val("mid_ctrl_rx", rd, 32'h0000_0069);

`ifdef SPI_WIDE_EN
    // 32-bit fast transfer
    bus_write(1'b1, 32'hD);
    start_xfer(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    wait_rdy(n);
    check_val("wide_busy", n, 32'd128);
    check_val("wide_mosi", mosi_log, 32'hDEAD_BEEF);
    bus_read(1'b0, rd);
    check_val("wide_rx", rd, 32'hDEAD_BEEF);
`else
    // Control bit 3 has no effect without the wide build
    bus_write(1'b1, 32'hD);
    start_xfer(32'hDEAD_BEEF, 32'hC300_0000);
    wait_rdy(n);
    check_val("nowide_busy", n, 32'd32);
    check_val("nowide_mosi", mosi_log, 32'h0000_00EF);
    bus_read(1'b0, rd);
    check_val("nowide_rx", rd, 32'h0000_00C3);
`endif

    // Reset during bit 4 of a slow transfer
    bus_write(1'b1, 32'h1);
    start_xfer(32'hA5, 32'h0000_0000);
    k = 0;
    while (rise_cnt < 4 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_val("abort_reach", rise_cnt, 32'd4);
    check_val("abort_sclk_hi", {31'd0, spi_sclk}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_sclk", {31'd0, spi_sclk}, 32'd0);
    check_val("abort_mosi", {31'd0, spi_mosi}, 32'd1);
    check_val("abort_ss_n", {30'd0, spi_ss_n}, 32'd3);
    bus_read(1'b1, rd);
    check_val("abort_rdy", rd, 32'h0000_0001);
    bus_read(1'b0, rd);
    check_val("abort_rx", rd, 32'h0000_0000);
    repeat (200) @(negedge clk);
    check_val("abort_idle", rise_cnt, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
